// File: rtl/seg7_pkg.sv
// Shared definitions for the 8-digit 7-segment scan display.
// Segment order is {g,f,e,d,c,b,a}. All patterns are active-low.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  // All segments off (active-low).
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low glyphs for hex digits 0..F.
  localparam logic [6:0] SEG_HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Digit position 0..7. Digit 0 is the rightmost digit.
  typedef logic [2:0] digitIdx_t;

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational converter from a hex nibble to an active-low 7-segment pattern.
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Look up the glyph for the current nibble.
  always_comb begin
    seg = SEG_HEX[nibble];
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed driver for an 8-digit common-anode 7-segment display.
// Digits 7..4 show the ValueHi snapshot and digits 3..0 show the ValueLo snapshot.
// Each digit slot lasts REFRESH_DIV cycles. All digits are dark for the first
// BLANK_CYCLES cycles of every slot, to prevent ghosting.
// Optional macro LEADING_ZERO_BLANK_EN darks the leading zero nibbles in each
// 4-digit half. Digits 0 and 4 always stay lit.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ValueHi,
  input  logic [15:0] ValueLo,
  input  logic        Load,
  output logic [6:0]  out7,
  output logic [7:0]  en_out
);

  localparam int               CNT_W     = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LIM = CNT_W'(BLANK_CYCLES);

  logic [CNT_W-1:0] cnt_r;
  digitIdx_t        idx_r;
  logic [15:0]      snapHi_r;
  logic [15:0]      snapLo_r;
  logic [15:0]      halfVal_s;
  logic [3:0]       nibble_s;
  logic [6:0]       seg_s;
  logic             inBlank_s;
  logic             digitDark_s;

  // Capture the display values when Load is high. The display reads only these copies.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      snapHi_r <= 16'h0000;
      snapLo_r <= 16'h0000;
    end else if (Load) begin
      snapHi_r <= ValueHi;
      snapLo_r <= ValueLo;
    end else begin
      snapHi_r <= snapHi_r;
      snapLo_r <= snapLo_r;
    end
  end

  // Slot counter. When the counter wraps, the scan moves to the next digit (7 wraps to 0).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_r <= '0;
      idx_r <= 3'd0;
    end else if (cnt_r == CNT_MAX) begin
      cnt_r <= '0;
      idx_r <= idx_r + 3'd1;
    end else begin
      cnt_r <= cnt_r + CNT_W'(1);
      idx_r <= idx_r;
    end
  end

  // Select the half-word and nibble for the digit currently being scanned.
  always_comb begin
    halfVal_s = 16'h0000;
    nibble_s  = 4'h0;
    if (idx_r[2]) begin
      halfVal_s = snapHi_r;
    end else begin
      halfVal_s = snapLo_r;
    end
    case (idx_r[1:0])
      2'd0:    nibble_s = halfVal_s[3:0];
      2'd1:    nibble_s = halfVal_s[7:4];
      2'd2:    nibble_s = halfVal_s[11:8];
      2'd3:    nibble_s = halfVal_s[15:12];
      default: nibble_s = 4'h0;
    endcase
  end

  // Decide whether the current digit is a leading zero that must stay dark.
  always_comb begin
    digitDark_s = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    case (idx_r[1:0])
      2'd1:    digitDark_s = (halfVal_s[15:4]  == 12'h000);
      2'd2:    digitDark_s = (halfVal_s[15:8]  == 8'h00);
      2'd3:    digitDark_s = (halfVal_s[15:12] == 4'h0);
      default: digitDark_s = 1'b0;
    endcase
`else
    digitDark_s = 1'b0;
`endif
  end

  // The anti-ghosting window covers the first BLANK_CYCLES counts of each slot.
  always_comb begin
    inBlank_s = (cnt_r < BLANK_LIM);
  end

  hex_to_seg7 u_hexToSeg7 (
    .nibble (nibble_s),
    .seg    (seg_s)
  );

  // Registered outputs. They lag cnt/idx by one cycle, and reset turns the display dark at once.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      out7   <= SEG_BLANK;
      en_out <= 8'hFF;
    end else if (inBlank_s || digitDark_s) begin
      out7   <= SEG_BLANK;
      en_out <= 8'hFF;
    end else begin
      out7   <= seg_s;
      en_out <= ~(8'b0000_0001 << idx_r);
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Directed testbench for seg7_scan_display with REFRESH_DIV=4 and BLANK_CYCLES=1.
// After a reset release, edge k shows the state left by edge k-1:
// digit = (k-1)/4 and count = (k-1)%4. Count 0 is the blank cycle.
module tb_seg7_scan_display;

  logic        Clk;
  logic        Reset;
  logic [15:0] ValueHi;
  logic [15:0] ValueLo;
  logic        Load;
  logic [6:0]  out7;
  logic [7:0]  en_out;

  int tests;
  int fails;

  seg7_scan_display #(
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .ValueHi (ValueHi),
    .ValueLo (ValueLo),
    .Load    (Load),
    .out7    (out7),
    .en_out  (en_out)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Advance one clock edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // Apply a one-cycle reset. On return the scan is at count 0, digit 0, and the outputs are dark.
  task automatic do_reset();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Load = 1'b0; ValueHi = 16'h0000; ValueLo = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (out7 !== 7'h7F || en_out !== 8'hFF) begin
        fails++;
        $display("FAIL reset_hold cyc%0d: out7=%h en_out=%h, want 7F FF", i, out7, en_out);
      end
    end
    Reset = 1'b0;
    tick();
    tests++;
    if (out7 !== 7'h7F || en_out !== 8'hFF) begin
      fails++;
      $display("FAIL reset_rel1: out7=%h en_out=%h, want 7F FF", out7, en_out);
    end
    tick();
    tests++;
    if (out7 !== 7'h40 || en_out !== 8'hFE) begin
      fails++;
      $display("FAIL reset_rel2: out7=%h en_out=%h, want 40 FE", out7, en_out);
    end
  endtask

  // Scan 1A2F / 0040 across all 8 digits, then check the wrap back to digit 0.
  task automatic test_scan();
    logic [6:0] expSeg [8];
    logic [7:0] expEn;
    logic [6:0] expOut;
    int d;
    expSeg = '{7'h0E, 7'h24, 7'h08, 7'h79, 7'h40, 7'h19, 7'h40, 7'h40};
    Load = 1'b1; ValueHi = 16'h0040; ValueLo = 16'h1A2F;
    do_reset();
    for (int k = 1; k <= 32; k++) begin
      tick();
      d = (k - 1) / 4;
      if (((k - 1) % 4) == 0) begin
        expEn = 8'hFF; expOut = 7'h7F;
      end else begin
        expEn = ~(8'b0000_0001 << d); expOut = expSeg[d];
      end
      tests++;
      if (en_out !== expEn || out7 !== expOut) begin
        fails++;
        $display("FAIL scan edge%0d digit%0d: out7=%h en_out=%h, want %h %h", k, d, out7, en_out, expOut, expEn);
      end
    end
    tick();
    tests++;
    if (en_out !== 8'hFF || out7 !== 7'h7F) begin
      fails++;
      $display("FAIL wrap_blank: out7=%h en_out=%h, want 7F FF", out7, en_out);
    end
    tick();
    tests++;
    if (en_out !== 8'hFE || out7 !== 7'h0E) begin
      fails++;
      $display("FAIL wrap_digit0: out7=%h en_out=%h, want 0E FE", out7, en_out);
    end
  endtask

  // A one-cycle Load mid-slot updates the lit digit. A later change without Load is ignored.
  task automatic test_load_pulse();
    Load = 1'b1; ValueHi = 16'h0000; ValueLo = 16'h0000;
    do_reset();
    tick();
    Load = 1'b0;
    tick();
    tests++;
    if (en_out !== 8'hFE || out7 !== 7'h40) begin
      fails++;
      $display("FAIL load_before: out7=%h en_out=%h, want 40 FE", out7, en_out);
    end
    ValueLo = 16'hFFFF; Load = 1'b1;
    tick();
    Load = 1'b0; ValueLo = 16'h1234;
    tests++;
    if (out7 !== 7'h40) begin
      fails++;
      $display("FAIL load_edge: out7=%h, want 40", out7);
    end
    tick();
    tests++;
    if (en_out !== 8'hFE || out7 !== 7'h0E) begin
      fails++;
      $display("FAIL load_next: out7=%h en_out=%h, want 0E FE", out7, en_out);
    end
    tick();
    tick();
    tests++;
    if (en_out !== 8'hFD || out7 !== 7'h0E) begin
      fails++;
      $display("FAIL no_load_hold: out7=%h en_out=%h, want 0E FD", out7, en_out);
    end
  endtask

  // Reset during digit 3 darkens the display on the next cycle and restarts the scan at digit 0.
  task automatic test_mid_reset();
    Load = 1'b1; ValueHi = 16'h0040; ValueLo = 16'h1A2F;
    do_reset();
    for (int k = 1; k <= 14; k++) tick();
    tests++;
    if (en_out !== 8'hF7 || out7 !== 7'h79) begin
      fails++;
      $display("FAIL pre_reset: out7=%h en_out=%h, want 79 F7", out7, en_out);
    end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tests++;
    if (en_out !== 8'hFF || out7 !== 7'h7F) begin
      fails++;
      $display("FAIL mid_reset_dark: out7=%h en_out=%h, want 7F FF", out7, en_out);
    end
    tick();
    tests++;
    if (en_out !== 8'hFF || out7 !== 7'h7F) begin
      fails++;
      $display("FAIL mid_reset_blank: out7=%h en_out=%h, want 7F FF", out7, en_out);
    end
    tick();
    tests++;
    if (en_out !== 8'hFE || out7 !== 7'h0E) begin
      fails++;
      $display("FAIL mid_reset_restart: out7=%h en_out=%h, want 0E FE", out7, en_out);
    end
  endtask

  // Display 0000 / 0042 with and without leading-zero blanking.
  task automatic test_leading_zero();
    logic [6:0] expSeg [8];
    logic [7:0] litMask;
    logic [7:0] expEn;
    logic [6:0] expOut;
    expSeg = '{7'h24, 7'h19, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
`ifdef LEADING_ZERO_BLANK_EN
    litMask = 8'b0001_0011;
`else
    litMask = 8'b1111_1111;
`endif
    Load = 1'b1; ValueHi = 16'h0000; ValueLo = 16'h0042;
    do_reset();
    tick();
    for (int d = 0; d < 8; d++) begin
      tick();
      if (litMask[d]) begin
        expEn = ~(8'b0000_0001 << d); expOut = expSeg[d];
      end else begin
        expEn = 8'hFF; expOut = 7'h7F;
      end
      tests++;
      if (en_out !== expEn || out7 !== expOut) begin
        fails++;
        $display("FAIL lzb digit%0d: out7=%h en_out=%h, want %h %h", d, out7, en_out, expOut, expEn);
      end
      tick(); tick(); tick();
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    Reset = 1'b1; Load = 1'b0; ValueHi = 16'h0000; ValueLo = 16'h0000;
    test_reset();
    test_scan();
    test_load_pulse();
    test_mid_reset();
    test_leading_zero();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
